// File: rtl/qos_ctrl_pkg.sv
// Shared types and constants for the compute-mode controller.
package qos_ctrl_pkg;

  localparam int unsigned MODE_W   = 4;
  localparam int unsigned RESULT_W = 8;

  localparam logic [MODE_W-1:0] DEFAULT_MODE   = 4'd14;
  localparam logic [3:0]        TIMEOUT_LED_HI = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    ABORT = 3'd3,
    HOLD  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and counter debounce for an active-low button;
// emits a one-cycle press_evt on each accepted press (never on release).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      stable    <= 1'b1;
      stable_d  <= 1'b1;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync1     <= btn_n;
      sync2     <= sync1;
      stable_d  <= stable;
      // Registered edge detect on the debounced level: one cycle after the flip.
      press_evt <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Steps the active compute mode on button presses, starts the mode engine,
// waits for completion with a timeout and latches the result onto the LEDs.
module mode_sequencer
  import qos_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                WF_CLK,
  input  logic                rst,
  input  logic                btn_n,
  output logic [MODE_W-1:0]   mode,
  output logic                eng_start,
  output logic                eng_abort,
  input  logic                eng_done,
  input  logic [RESULT_W-1:0] eng_result,
  output logic [RESULT_W-1:0] led,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              press_evt;
  logic              abort_by_press;
  logic              tmo_hit;
  logic [TCNT_W-1:0] tcnt;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (WF_CLK),
    .rst       (rst),
    .btn_n     (btn_n),
    .press_evt (press_evt)
  );

  assign tmo_hit = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  // A press always wins over completion or timeout in the same RUN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = START;
      START: state_nxt = press_evt ? ABORT : RUN;
      RUN: begin
        if (press_evt)     state_nxt = ABORT;
        else if (eng_done) state_nxt = HOLD;
        else if (tmo_hit)  state_nxt = ABORT;
      end
      ABORT: state_nxt = (abort_by_press || press_evt) ? START : HOLD;
      HOLD:  state_nxt = press_evt ? START : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state_nxt so each registered strobe lines up
  // with the state it belongs to.
  always_ff @(posedge WF_CLK) begin
    if (rst) begin
      state          <= IDLE;
      mode           <= DEFAULT_MODE;
      led            <= '0;
      eng_start      <= 1'b0;
      eng_abort      <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      tcnt           <= '0;
      abort_by_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      eng_start <= (state_nxt == START);
      eng_abort <= (state_nxt == ABORT);
      busy      <= (state_nxt == START) || (state_nxt == RUN);

      if (press_evt) begin
        mode <= mode + MODE_W'(1);
      end

      if (state_nxt == START) begin
        tcnt        <= '0;
        timeout_err <= 1'b0;
      end else if (state == RUN) begin
        tcnt <= tcnt + TCNT_W'(1);
      end

      if (state == RUN && !press_evt) begin
        if (eng_done) begin
          led <= eng_result;
        end else if (tmo_hit) begin
          timeout_err <= 1'b1;
          led         <= RESULT_W'({TIMEOUT_LED_HI, mode[3:0]});
        end
      end

      if (state_nxt == ABORT) begin
        abort_by_press <= press_evt;
      end
    end
  end

endmodule
